mips_cpu_core: RTL and testbench



---
 rtl/mips_cpu_core.sv | 176 +++++++++++++++++
 tb/tb_mips_cpu_core.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_core.sv
// Single-cycle 32-bit MIPS-subset core: fetch, decode, execute and retire one instruction per clock.
// Memories and register file are deliberately never cleared so hierarchical preloads survive reset.

module mips_instruction_memory #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   instr
);
    logic [31:0] ram [DEPTH];

    assign instr = ram[addr];
endmodule

module mips_register_file (
    input  logic        clock,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] r [32];

    // Reads see the pre-edge value, so an instruction reading its own destination gets the old data.
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : r[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : r[ra2];

    always_ff @(posedge clock) begin
        if (we && wa != 5'd0) begin
            r[wa] <= wd;
        end
    end
endmodule

module mips_data_memory #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);
    logic [31:0] ram [DEPTH];

    assign rd = ram[addr];

    always_ff @(posedge clock) begin
        if (we) begin
            ram[addr] <= wd;
        end
    end
endmodule

module mips_cpu_core #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] program_counter
);
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    logic [IW-1:0] pc;
    logic [IW-1:0] pc_next;
    logic [IW-1:0] pc_plus1;
    logic [31:0]   instr;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [31:0]   simm;
    logic [31:0]   rs_val;
    logic [31:0]   rt_val;
    logic [31:0]   eff_addr;
    logic [31:0]   dmem_rdata;
    logic [31:0]   wb_data;
    logic [4:0]    wb_addr;
    logic          wb_en;
    logic          mem_we;
    logic          commit;

    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign simm     = {{16{instr[15]}}, instr[15:0]};
    assign eff_addr = rs_val + simm;
    assign pc_plus1 = pc + IW'(1);

    // Writes only happen on an executing edge; a low reset at the edge suppresses them too.
    assign commit   = start & reset;

    mips_instruction_memory #(.DEPTH(IMEM_DEPTH), .AW(IW)) my_Instruction_Memory (
        .addr  (pc),
        .instr (instr)
    );

    mips_register_file my_RegisterFile (
        .clock (clock),
        .we    (wb_en & commit),
        .ra1   (rs),
        .ra2   (rt),
        .wa    (wb_addr),
        .wd    (wb_data),
        .rd1   (rs_val),
        .rd2   (rt_val)
    );

    mips_data_memory #(.DEPTH(DMEM_DEPTH), .AW(DW)) my_Data_Memory (
        .clock (clock),
        .we    (mem_we & commit),
        .addr  (eff_addr[DW-1:0]),
        .wd    (rt_val),
        .rd    (dmem_rdata)
    );

    always_comb begin
        wb_data = 32'd0;
        wb_addr = rd;
        wb_en   = 1'b0;
        mem_we  = 1'b0;
        pc_next = pc_plus1;
        case (op)
            6'b000000: begin
                wb_en = 1'b1;
                case (funct)
                    6'b100000: wb_data = rs_val + rt_val;
                    6'b100010: wb_data = rs_val - rt_val;
                    6'b100100: wb_data = rs_val & rt_val;
                    6'b100101: wb_data = rs_val | rt_val;
                    6'b101010: wb_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    6'b000000: wb_data = rt_val << shamt;
                    default:   wb_en   = 1'b0;
                endcase
            end
            6'b001000: begin
                wb_addr = rt;
                wb_data = eff_addr;
                wb_en   = 1'b1;
            end
            6'b100011: begin
                wb_addr = rt;
                wb_data = dmem_rdata;
                wb_en   = 1'b1;
            end
            6'b101011: mem_we = 1'b1;
            6'b000100: if (rs_val == rt_val) pc_next = pc_plus1 + simm[IW-1:0];
            6'b000101: if (rs_val != rt_val) pc_next = pc_plus1 + simm[IW-1:0];
            6'b000010: pc_next = instr[IW-1:0];
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (!start) begin
            pc <= program_counter[IW-1:0];
        end else begin
            pc <= pc_next;
        end
    end
endmodule

// File: tb/tb_mips_cpu_core.sv
// Directed bench for mips_cpu_core: single-instruction vector table plus short multi-cycle programs.

module tb_mips_cpu_core;
    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] pc_in;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] SENT = 32'hA5A5_A5A5;

    mips_cpu_core dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .program_counter (pc_in)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [4:0]  a_reg;
        logic [31:0] a_val;
        logic [4:0]  b_reg;
        logic [31:0] b_val;
        logic [4:0]  chk_reg;
        logic [31:0] chk_exp;
        logic [31:0] pc_exp;
    } vec_t;

    function automatic logic [31:0] rtype(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic load_pc(input logic [31:0] target);
        start = 1'b0;
        pc_in = target;
        step();
    endtask

    vec_t vecs[19];
    int   exp_pc[5];

    initial begin
        vecs[0]  = '{"add_r0",    rtype(1, 2, 0, 0, 32'h20), 1, 32'd5,        2, 32'd7,        0, 32'd0,        1};
        vecs[1]  = '{"slt_neg",   rtype(9, 10, 8, 0, 32'h2A), 9, 32'hFFFFFFFF, 10, 32'd1,      8, 32'd1,        1};
        vecs[2]  = '{"slt_pos",   rtype(10, 9, 8, 0, 32'h2A), 9, 32'hFFFFFFFF, 10, 32'd1,      8, 32'd0,        1};
        vecs[3]  = '{"sub",       rtype(1, 2, 4, 0, 32'h22), 1, 32'd0,        2, 32'd1,        4, 32'hFFFFFFFF, 1};
        vecs[4]  = '{"and",       rtype(1, 2, 4, 0, 32'h24), 1, 32'hF0F0,     2, 32'hFF00,     4, 32'hF000,     1};
        vecs[5]  = '{"or",        rtype(1, 2, 4, 0, 32'h25), 1, 32'hF0F0,     2, 32'hFF00,     4, 32'hFFF0,     1};
        vecs[6]  = '{"sll",       rtype(0, 2, 4, 4, 32'h00), 1, 32'd0,        2, 32'd3,        4, 32'h30,       1};
        vecs[7]  = '{"add_wrap",  rtype(1, 2, 4, 0, 32'h20), 1, 32'hFFFFFFFF, 2, 32'd2,        4, 32'd1,        1};
        vecs[8]  = '{"add_old",   rtype(1, 2, 1, 0, 32'h20), 1, 32'd3,        2, 32'd4,        1, 32'd7,        1};
        vecs[9]  = '{"bad_funct", rtype(1, 2, 4, 0, 32'h27), 1, 32'd3,        2, 32'd4,        4, SENT,         1};
        vecs[10] = '{"bad_op",    itype(32'h3F, 1, 4, 32'h1234), 1, 32'd3,    2, 32'd4,        4, SENT,         1};
        vecs[11] = '{"addi_neg",  itype(8, 0, 6, 32'hFFFF), 1, 32'd9,         2, 32'd4,        6, 32'hFFFFFFFF, 1};
        vecs[12] = '{"addi_pos",  itype(8, 1, 6, 32'h0010), 1, 32'h100,       2, 32'd4,        6, 32'h110,      1};
        vecs[13] = '{"beq_taken", itype(4, 1, 2, 5), 1, 32'd9,                2, 32'd9,        4, SENT,         6};
        vecs[14] = '{"beq_wrap",  itype(4, 1, 2, 32'hFFFE), 1, 32'd9,         2, 32'd9,        4, SENT,         255};
        vecs[15] = '{"bne_not",   itype(5, 1, 2, 5), 1, 32'd9,                2, 32'd9,        4, SENT,         1};
        vecs[16] = '{"bne_taken", itype(5, 1, 2, 3), 1, 32'd9,                2, 32'd8,        4, SENT,         4};
        vecs[17] = '{"j_mod",     {6'b000010, 26'h3FFFF05}, 1, 32'd9,         2, 32'd8,        4, SENT,         5};
        vecs[18] = '{"lw_mod",    itype(32'h23, 1, 7, 3), 1, 32'h101,         2, 32'd8,        7, 32'hCAFEF00D, 1};

        reset = 1'b0;
        start = 1'b0;
        pc_in = 32'd0;
        dut.my_RegisterFile.r[0] = 32'd0;
        dut.my_Data_Memory.ram[4] = 32'hCAFEF00D;
        #12;
        check("reset_pc", 32'(dut.pc), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Single-instruction vectors, each executed from PC 0.
        for (int i = 0; i < 19; i++) begin
            start = 1'b0;
            pc_in = 32'd0;
            dut.my_Instruction_Memory.ram[0] = vecs[i].instr;
            if (vecs[i].chk_reg != 5'd0) dut.my_RegisterFile.r[vecs[i].chk_reg] = SENT;
            dut.my_RegisterFile.r[vecs[i].a_reg] = vecs[i].a_val;
            dut.my_RegisterFile.r[vecs[i].b_reg] = vecs[i].b_val;
            step();
            start = 1'b1;
            step();
            start = 1'b0;
            $display("vec %-10s instr=%h r%0d=%h pc=%0d", vecs[i].name, vecs[i].instr,
                     vecs[i].chk_reg, dut.my_RegisterFile.r[vecs[i].chk_reg], dut.pc);
            check({vecs[i].name, "_reg"}, dut.my_RegisterFile.r[vecs[i].chk_reg], vecs[i].chk_exp);
            check({vecs[i].name, "_pc"}, 32'(dut.pc), vecs[i].pc_exp);
        end

        // Baseline program: taken beq skips ram[1].
        dut.my_Instruction_Memory.ram[0] = 32'h10220001;
        dut.my_Instruction_Memory.ram[1] = 32'd0;
        dut.my_Instruction_Memory.ram[2] = rtype(1, 2, 1, 0, 32'h20);
        dut.my_Instruction_Memory.ram[3] = rtype(2, 1, 3, 0, 32'h20);
        dut.my_Instruction_Memory.ram[4] = itype(8, 3, 5, 1);
        dut.my_Instruction_Memory.ram[5] = itype(32'h2B, 0, 2, 1);
        dut.my_Instruction_Memory.ram[6] = 32'd0;
        dut.my_RegisterFile.r[1] = 32'd6;
        dut.my_RegisterFile.r[2] = 32'd6;
        dut.my_RegisterFile.r[3] = 32'd0;
        dut.my_RegisterFile.r[5] = 32'd0;
        dut.my_Data_Memory.ram[1] = 32'd0;
        load_pc(32'd0);
        check("base_pc0", 32'(dut.pc), 32'd0);
        exp_pc = '{2, 3, 4, 5, 6};
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            $display("base step %0d pc=%0d", i, dut.pc);
            check($sformatf("base_pc%0d", i + 1), 32'(dut.pc), exp_pc[i]);
        end
        start = 1'b0;
        check("base_r1", dut.my_RegisterFile.r[1], 32'd12);
        check("base_r3", dut.my_RegisterFile.r[3], 32'd18);
        check("base_r5", dut.my_RegisterFile.r[5], 32'd19);
        check("base_dmem1", dut.my_Data_Memory.ram[1], 32'd6);

        // Branch not taken, then the NOP at ram[1] must leave state alone.
        dut.my_RegisterFile.r[1] = 32'd6;
        dut.my_RegisterFile.r[2] = 32'd7;
        dut.my_RegisterFile.r[3] = 32'd0;
        dut.my_Data_Memory.ram[1] = 32'd0;
        load_pc(32'd0);
        start = 1'b1;
        step();
        check("bnt_pc1", 32'(dut.pc), 32'd1);
        step();
        start = 1'b0;
        $display("nop pc=%0d r1=%h", dut.pc, dut.my_RegisterFile.r[1]);
        check("nop_pc2", 32'(dut.pc), 32'd2);
        check("nop_r1", dut.my_RegisterFile.r[1], 32'd6);
        check("nop_r3", dut.my_RegisterFile.r[3], 32'd0);
        check("nop_dmem1", dut.my_Data_Memory.ram[1], 32'd0);

        // sw then lw through the same address, then a negative addi.
        dut.my_Instruction_Memory.ram[0] = itype(32'h2B, 0, 2, 4);
        dut.my_Instruction_Memory.ram[1] = itype(32'h23, 0, 7, 4);
        dut.my_Instruction_Memory.ram[2] = itype(8, 0, 6, 32'hFFFF);
        dut.my_RegisterFile.r[2] = 32'hDEADBEEF;
        dut.my_RegisterFile.r[6] = 32'd0;
        dut.my_RegisterFile.r[7] = 32'd0;
        load_pc(32'd0);
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        $display("swlw dmem4=%h r7=%h r6=%h", dut.my_Data_Memory.ram[4],
                 dut.my_RegisterFile.r[7], dut.my_RegisterFile.r[6]);
        check("sw_dmem4", dut.my_Data_Memory.ram[4], 32'hDEADBEEF);
        check("lw_r7", dut.my_RegisterFile.r[7], 32'hDEADBEEF);
        check("addi_r6", dut.my_RegisterFile.r[6], 32'hFFFFFFFF);

        // PC load while held, upper bits wrap modulo depth.
        load_pc(32'd4);
        check("load_pc4", 32'(dut.pc), 32'd4);
        load_pc(32'h107);
        $display("load pc=%0d", dut.pc);
        check("load_pc_mod", 32'(dut.pc), 32'd7);

        // Reset mid-run: PC clears before the edge and that edge writes nothing.
        dut.my_Instruction_Memory.ram[7] = itype(8, 0, 11, 32'h55);
        dut.my_Instruction_Memory.ram[0] = itype(32'h2B, 0, 2, 8);
        dut.my_RegisterFile.r[2] = 32'h1234;
        dut.my_RegisterFile.r[11] = 32'd0;
        dut.my_Data_Memory.ram[8] = 32'd0;
        start = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_pc", 32'(dut.pc), 32'd0);
        step();
        check("rst_edge_pc", 32'(dut.pc), 32'd0);
        check("rst_no_regwr", dut.my_RegisterFile.r[11], 32'd0);
        check("rst_no_memwr", dut.my_Data_Memory.ram[8], 32'd0);
        reset = 1'b1;
        step();
        start = 1'b0;
        $display("after reset pc=%0d dmem8=%h", dut.pc, dut.my_Data_Memory.ram[8]);
        check("rst_resume_pc", 32'(dut.pc), 32'd1);
        check("rst_resume_mem", dut.my_Data_Memory.ram[8], 32'h1234);

        // j 3 then a beq -1 that spins on itself.
        dut.my_Instruction_Memory.ram[0] = 32'h08000003;
        dut.my_Instruction_Memory.ram[3] = itype(4, 1, 1, 32'hFFFF);
        load_pc(32'd0);
        start = 1'b1;
        step();
        check("j3_pc", 32'(dut.pc), 32'd3);
        for (int i = 0; i < 2; i++) begin
            step();
            $display("loop step %0d pc=%0d", i, dut.pc);
            check($sformatf("loop_pc%0d", i), 32'(dut.pc), 32'd3);
        end
        start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
